// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: initiator side of the 128-bit line memory interface.
// Arbitrates I-cache fill, D-cache fill and D-cache writeback requests and
// runs one fixed-latency RAM access at a time. A granted access walks
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   ic_req/ic_addr                  I-cache fill request and address
//   ic_done/ic_line                 I-cache fill completion pulse and data
//   dc_rd_req/dc_rd_addr            D-cache fill request and address
//   dc_rd_done/dc_rd_line           D-cache fill completion pulse and data
//   dc_wr_req/dc_wr_addr/dc_wr_line D-cache writeback request, address, data
//   dc_wr_done                      D-cache writeback completion pulse
//   data_requested/where_to_write   RAM read / write address
//   data_to_write/write_to_mem      RAM write data / write strobe
//   data_returned                   RAM read data
//   busy                            high whenever not IDLE
module mem_req_ctrl #(
  parameter int unsigned MEM_LATENCY  = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_req,
  input  logic [19:0]  ic_addr,
  output logic         ic_done,
  output logic [127:0] ic_line,
  input  logic         dc_rd_req,
  input  logic [19:0]  dc_rd_addr,
  output logic         dc_rd_done,
  output logic [127:0] dc_rd_line,
  input  logic         dc_wr_req,
  input  logic [19:0]  dc_wr_addr,
  input  logic [127:0] dc_wr_line,
  output logic         dc_wr_done,
  output logic [19:0]  data_requested,
  output logic [19:0]  where_to_write,
  output logic [127:0] data_to_write,
  output logic         write_to_mem,
  input  logic [127:0] data_returned,
  output logic         busy
);

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SRC_IC, SRC_DRD, SRC_DWR} src_e;

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               ic_done_d, dc_rd_done_d, dc_wr_done_d, write_d, busy_d;
  logic [ADDR_W-1:0]  rd_addr_d, wr_addr_d;
  logic [LINE_W-1:0]  wr_data_d, ic_line_d, dc_rd_line_d;

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    rd_addr_d    = data_requested;
    wr_addr_d    = where_to_write;
    wr_data_d    = data_to_write;
    ic_line_d    = ic_line;
    dc_rd_line_d = dc_rd_line;
    ic_done_d    = 1'b0;
    dc_rd_done_d = 1'b0;
    dc_wr_done_d = 1'b0;
    write_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ic_req) starve_d = '0;
        // Starvation override beats the fixed D-side priority.
        if (ic_req && (starve_q == CNT_W'(STARVE_LIMIT))) begin
          src_d     = SRC_IC;
          rd_addr_d = ic_addr;
          starve_d  = '0;
          state_d   = ISSUE;
        end else if (dc_wr_req) begin
          src_d     = SRC_DWR;
          wr_addr_d = dc_wr_addr;
          wr_data_d = dc_wr_line;
          write_d   = 1'b1;
          state_d   = ISSUE;
          if (ic_req && (starve_q != CNT_W'(STARVE_LIMIT))) starve_d = starve_q + CNT_W'(1);
        end else if (dc_rd_req) begin
          src_d     = SRC_DRD;
          rd_addr_d = dc_rd_addr;
          state_d   = ISSUE;
          if (ic_req && (starve_q != CNT_W'(STARVE_LIMIT))) starve_d = starve_q + CNT_W'(1);
        end else if (ic_req) begin
          src_d     = SRC_IC;
          rd_addr_d = ic_addr;
          starve_d  = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = CNT_W'(MEM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - CNT_W'(1);
        // Capture edge: line data and done pulse register together.
        if (lat_q == CNT_W'(1)) begin
          state_d = RESP;
          case (src_q)
            SRC_IC: begin
              ic_line_d = data_returned;
              ic_done_d = 1'b1;
            end
            SRC_DRD: begin
              dc_rd_line_d = data_returned;
              dc_rd_done_d = 1'b1;
            end
            default: dc_wr_done_d = 1'b1;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      src_q          <= SRC_IC;
      lat_q          <= '0;
      starve_q       <= '0;
      data_requested <= '0;
      where_to_write <= '0;
      data_to_write  <= '0;
      write_to_mem   <= 1'b0;
      ic_line        <= '0;
      dc_rd_line     <= '0;
      ic_done        <= 1'b0;
      dc_rd_done     <= 1'b0;
      dc_wr_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      lat_q          <= lat_d;
      starve_q       <= starve_d;
      data_requested <= rd_addr_d;
      where_to_write <= wr_addr_d;
      data_to_write  <= wr_data_d;
      write_to_mem   <= write_d;
      ic_line        <= ic_line_d;
      dc_rd_line     <= dc_rd_line_d;
      ic_done        <= ic_done_d;
      dc_rd_done     <= dc_rd_done_d;
      dc_wr_done     <= dc_wr_done_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a MEM_LATENCY=5 instance carries the
// traffic, a MEM_LATENCY=1 instance shares its inputs for the short-latency case.
module tb_mem_req_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req, dc_rd_req, dc_wr_req;
  logic [19:0]  ic_addr, dc_rd_addr, dc_wr_addr;
  logic [127:0] dc_wr_line, data_returned, l1_data_returned;

  logic         ic_done, dc_rd_done, dc_wr_done, write_to_mem, busy;
  logic [127:0] ic_line, dc_rd_line, data_to_write;
  logic [19:0]  data_requested, where_to_write;

  logic         l1_ic_done, l1_dc_rd_done, l1_dc_wr_done, l1_write_to_mem, l1_busy;
  logic [127:0] l1_ic_line, l1_dc_rd_line, l1_data_to_write;
  logic [19:0]  l1_data_requested, l1_where_to_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: the returned line is the read address replicated.
  function automatic logic [127:0] pat(input logic [19:0] a);
    return {4{12'h000, a}};
  endfunction

  assign data_returned    = pat(data_requested);
  assign l1_data_returned = pat(l1_data_requested);

  mem_req_ctrl #(.MEM_LATENCY(5), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_line(ic_line),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_done(dc_rd_done),
    .dc_rd_line(dc_rd_line),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_line(dc_wr_line),
    .dc_wr_done(dc_wr_done),
    .data_requested(data_requested), .where_to_write(where_to_write),
    .data_to_write(data_to_write), .write_to_mem(write_to_mem),
    .data_returned(data_returned), .busy(busy)
  );

  mem_req_ctrl #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(l1_ic_done), .ic_line(l1_ic_line),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_done(l1_dc_rd_done),
    .dc_rd_line(l1_dc_rd_line),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_line(dc_wr_line),
    .dc_wr_done(l1_dc_wr_done),
    .data_requested(l1_data_requested), .where_to_write(l1_where_to_write),
    .data_to_write(l1_data_to_write), .write_to_mem(l1_write_to_mem),
    .data_returned(l1_data_returned), .busy(l1_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Results of the last watch() window; n values are cycles after the start edge.
  int n_ic, n_rd, n_wr, n2_ic, cnt_ic, cnt_rd, cnt_wr, wr_hi, done_cnt;
  logic [11:0]  seq;
  logic [127:0] ic_pre, l2_line;

  // Step up to max_cyc cycles, logging done pulses and dropping each
  // request on its done (dc_rd_req kept when hold_rd).
  task automatic watch(input int max_cyc, input int stop_after, input bit hold_rd);
    logic [127:0] prev;
    prev = ic_line;
    n_ic = -1; n_rd = -1; n_wr = -1; n2_ic = -1;
    cnt_ic = 0; cnt_rd = 0; cnt_wr = 0; wr_hi = 0; done_cnt = 0;
    seq = '0; ic_pre = '0; l2_line = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      step();
      if (write_to_mem) wr_hi++;
      if (l1_ic_done && n2_ic < 0) begin
        n2_ic   = n;
        l2_line = l1_ic_line;
      end
      if (ic_done) begin
        if (n_ic < 0) begin
          n_ic   = n;
          ic_pre = prev;
        end
        cnt_ic++; done_cnt++;
        seq    = {seq[9:0], 2'd1};
        ic_req = 1'b0;
      end
      if (dc_rd_done) begin
        if (n_rd < 0) n_rd = n;
        cnt_rd++; done_cnt++;
        seq = {seq[9:0], 2'd2};
        if (!hold_rd) dc_rd_req = 1'b0;
      end
      if (dc_wr_done) begin
        if (n_wr < 0) n_wr = n;
        cnt_wr++; done_cnt++;
        seq       = {seq[9:0], 2'd3};
        dc_wr_req = 1'b0;
      end
      prev = ic_line;
      if (stop_after != 0 && done_cnt >= stop_after) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) step();
    check(tag, 128'(busy), 128'(0));
  endtask

  localparam logic [127:0] WR_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  initial begin
    reset = 1'b0;
    ic_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    ic_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0; dc_wr_line = '0;
    step(); step();

    // Reset state.
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wr", 128'(write_to_mem), 128'(0));
    check("rst_rdaddr", 128'(data_requested), 128'(0));
    check("rst_icline", ic_line, 128'(0));
    check("rst_icdone", 128'(ic_done), 128'(0));

    // Single I-fill on both latencies.
    reset = 1'b1; ic_req = 1'b1; ic_addr = 20'h00010;
    step();
    check("ic_issue_addr", 128'(data_requested), 128'(20'h00010));
    check("ic_issue_busy", 128'(busy), 128'(1));
    check("ic_issue_wr", 128'(write_to_mem), 128'(0));
    watch(20, 1, 1'b0);
    check("ic_done_lat", 128'(n_ic), 128'(6));
    check("ic_line_pre", ic_pre, 128'(0));
    check("ic_line", ic_line, pat(20'h00010));
    check("ic_no_wr", 128'(wr_hi), 128'(0));
    check("l1_done_lat", 128'(n2_ic), 128'(2));
    check("l1_line", l2_line, pat(20'h00010));
    wait_idle("idle_ic");

    // Single writeback.
    dc_wr_req = 1'b1; dc_wr_addr = 20'h00400; dc_wr_line = WR_DATA;
    step();
    check("wr_addr", 128'(where_to_write), 128'(20'h00400));
    check("wr_data", data_to_write, WR_DATA);
    check("wr_strobe", 128'(write_to_mem), 128'(1));
    watch(12, 0, 1'b0);
    check("wr_strobe_once", 128'(wr_hi), 128'(0));
    check("wr_done_lat", 128'(n_wr), 128'(6));
    check("wr_done_cnt", 128'(cnt_wr), 128'(1));
    check("wr_no_rd_done", 128'(cnt_rd), 128'(0));
    check("wr_no_ic_done", 128'(cnt_ic), 128'(0));
    check("wr_data_hold", data_to_write, WR_DATA);

    // All three sources raised together.
    dc_wr_req = 1'b1; dc_wr_addr = 20'h00800; dc_wr_line = ~WR_DATA;
    dc_rd_req = 1'b1; dc_rd_addr = 20'h0A5A5;
    ic_req    = 1'b1; ic_addr    = 20'h00C30;
    step();
    watch(40, 3, 1'b0);
    check("arb_wr_done", 128'(n_wr), 128'(6));
    check("arb_rd_done", 128'(n_rd), 128'(14));
    check("arb_ic_done", 128'(n_ic), 128'(22));
    check("arb_rd_line", dc_rd_line, pat(20'h0A5A5));
    check("arb_ic_line", ic_line, pat(20'h00C30));
    check("arb_wr_data", data_to_write, ~WR_DATA);
    wait_idle("idle_arb");

    // Starvation: I-side forced after four D-reads, then a fifth D-read.
    ic_req = 1'b1; ic_addr = 20'h01111;
    dc_rd_req = 1'b1; dc_rd_addr = 20'h02222;
    watch(80, 6, 1'b1);
    dc_rd_req = 1'b0;
    check("starve_seq", 128'(seq), 128'(12'hAA6));
    check("starve_ic_line", ic_line, pat(20'h01111));
    wait_idle("idle_starve");

    // Reset in the middle of WAIT.
    ic_req = 1'b1; ic_addr = 20'h00123;
    step(); step(); step();
    reset = 1'b0;
    step();
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(ic_done), 128'(0));
    check("mid_rst_icline", ic_line, 128'(0));
    check("mid_rst_rdline", dc_rd_line, 128'(0));
    reset = 1'b1; ic_addr = 20'h00200;
    step();
    watch(20, 1, 1'b0);
    check("post_rst_lat", 128'(n_ic), 128'(6));
    check("post_rst_line", ic_line, pat(20'h00200));
    wait_idle("idle_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
